irrigation_timer: RTL

Synchronous watering-duration timer that consumes the slow divided timebase produced by the ripple clock divider and drives the valve enable for a programmed number of time units. It synchronises the divider output into the `clk` domain, detects its rising edges, and counts them down against a duration latched on a start request. It sits between the divider and the valve/LED output logic of the residential irrigation controller.

---
 rtl/irrigation_timer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/irrigation_timer.sv
// Watering-duration timer: counts synchronised rising edges of the divided
// timebase and holds the valve open for a latched number of time units.
module irrigation_timer #(
  parameter int W        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  input  logic         start,
  input  logic [W-1:0] duration,
  input  logic         hold,
  input  logic         abort,
  output logic         valve,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic [W-1:0] remaining
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           s1;
  logic           s2;
  logic           s3;
  logic           tick;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] pc_next;
  logic [W-1:0]   remaining_next;
  logic           valve_next;
  logic           busy_next;
  logic           done_next;
  logic           aborted_next;
  logic           unit_end;
  logic           last_unit;

  // tick_in is asynchronous: two flops for metastability, a third for edge detect
  assign tick      = s2 & ~s3;
  assign unit_end  = tick && (pc == PC_LAST);
  assign last_unit = unit_end && (remaining == W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= IDLE;
      pc        <= '0;
      remaining <= '0;
      valve     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      s1        <= tick_in;
      s2        <= s1;
      s3        <= s2;
      state     <= state_next;
      pc        <= pc_next;
      remaining <= remaining_next;
      valve     <= valve_next;
      busy      <= busy_next;
      done      <= done_next;
      aborted   <= aborted_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    remaining_next = remaining;
    valve_next     = valve;
    busy_next      = busy;
    done_next      = 1'b0;
    aborted_next   = 1'b0;

    case (state)
      IDLE: begin
        valve_next     = 1'b0;
        busy_next      = 1'b0;
        remaining_next = '0;
        pc_next        = '0;
        if (start && !abort) begin
          if (duration == '0) begin
            done_next = 1'b1;
          end else begin
            remaining_next = duration;
            busy_next      = 1'b1;
            if (hold) begin
              state_next = PAUSE;
              valve_next = 1'b0;
            end else begin
              state_next = RUN;
              valve_next = 1'b1;
            end
          end
        end
      end

      RUN: begin
        // Order of tests encodes priority: abort, completion, hold, tick
        if (abort) begin
          state_next     = IDLE;
          valve_next     = 1'b0;
          busy_next      = 1'b0;
          remaining_next = '0;
          pc_next        = '0;
          aborted_next   = 1'b1;
        end else if (last_unit) begin
          state_next     = IDLE;
          valve_next     = 1'b0;
          busy_next      = 1'b0;
          remaining_next = '0;
          pc_next        = '0;
          done_next      = 1'b1;
        end else if (hold) begin
          state_next = PAUSE;
          valve_next = 1'b0;
        end else if (tick) begin
          if (unit_end) begin
            pc_next = '0;
            if (remaining != '0) begin
              remaining_next = remaining - W'(1);
            end
          end else begin
            pc_next = pc + PCW'(1);
          end
        end
      end

      PAUSE: begin
        if (abort) begin
          state_next     = IDLE;
          valve_next     = 1'b0;
          busy_next      = 1'b0;
          remaining_next = '0;
          pc_next        = '0;
          aborted_next   = 1'b1;
        end else if (!hold) begin
          state_next = RUN;
          valve_next = 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        valve_next     = 1'b0;
        busy_next      = 1'b0;
        remaining_next = '0;
        pc_next        = '0;
      end
    endcase
  end

endmodule
